// File: rtl/decode_pkg.sv
// Shared opcode map, ALU op codes and the decoded-instruction record
// used by the combinational decoder and the decode/execute pipeline stage.
`timescale 1ns/1ps
package decode_pkg;

  localparam logic [5:0] OPC_ADD  = 6'd0;
  localparam logic [5:0] OPC_SUB  = 6'd1;
  localparam logic [5:0] OPC_AND  = 6'd2;
  localparam logic [5:0] OPC_OR   = 6'd3;
  localparam logic [5:0] OPC_XOR  = 6'd4;
  localparam logic [5:0] OPC_NOR  = 6'd5;
  localparam logic [5:0] OPC_SHL  = 6'd6;
  localparam logic [5:0] OPC_SHR  = 6'd7;
  localparam logic [5:0] OPC_ADDI = 6'd8;
  localparam logic [5:0] OPC_LT   = 6'd9;
  localparam logic [5:0] OPC_GT   = 6'd10;
  localparam logic [5:0] OPC_CTRL = 6'd13;
  localparam logic [5:0] OPC_MUL  = 6'd14;
  // Loads and stores ignore opc[5]; that bit selects byte access.
  localparam logic [4:0] OPC_LOAD_LO  = 5'b01011;
  localparam logic [4:0] OPC_STORE_LO = 5'b01100;

  localparam logic [4:0] RD_BEQ = 5'd1;
  localparam logic [4:0] RD_BLT = 5'd2;
  localparam logic [4:0] RD_BGT = 5'd3;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_EQ  = 4'd8;
  localparam logic [3:0] ALU_LT  = 4'd9;
  localparam logic [3:0] ALU_GT  = 4'd10;
  localparam logic [3:0] ALU_MUL = 4'd11;

  typedef struct packed {
    logic [5:0]  opc;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic [10:0] imm;
    logic [3:0]  alu_op;
    logic        we;
    logic        ld;
    logic        str;
    logic        byt;
    logic        brn;
    logic        jmp;
    logic        jlx;
    logic        addi;
    logic        mul;
    logic        ill;
  } dec_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational instruction decoder: 32-bit word to dec_t record.
// The immediate stays 11 bits here; widening is left to the consumer.
`timescale 1ns/1ps
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [5:0] opc;
  logic [4:0] rd;
  logic       is_ctrl;
  logic       beq;
  logic       blt;
  logic       bgt;

  always_comb begin
    opc     = inst_i[31:26];
    rd      = inst_i[15:11];
    is_ctrl = (opc == OPC_CTRL);
    beq     = is_ctrl & (rd == RD_BEQ);
    blt     = is_ctrl & (rd == RD_BLT);
    bgt     = is_ctrl & (rd == RD_BGT);

    dec_o      = '0;
    dec_o.opc  = opc;
    dec_o.ra   = inst_i[25:21];
    dec_o.rb   = inst_i[20:16];
    dec_o.rd   = rd;
    dec_o.imm  = inst_i[10:0];
    dec_o.ld   = (opc[4:0] == OPC_LOAD_LO);
    dec_o.str  = (opc[4:0] == OPC_STORE_LO);
    dec_o.byt  = opc[5];
    dec_o.mul  = (opc == OPC_MUL);
    dec_o.addi = (opc == OPC_ADDI);
    dec_o.brn  = is_ctrl;
    dec_o.jmp  = is_ctrl & (rd[3:0] == 4'd0);
    dec_o.jlx  = dec_o.jmp & rd[4];
    // Everything up to MUL is mapped; above that only byte load/store exist.
    dec_o.ill  = ~((opc <= OPC_MUL) | dec_o.ld | dec_o.str);
    dec_o.we   = (opc <= OPC_GT) | dec_o.ld | dec_o.mul;

    if (opc <= OPC_SHR)                 dec_o.alu_op = opc[3:0];
    else if (beq)                       dec_o.alu_op = ALU_EQ;
    else if ((opc == OPC_LT) | blt)     dec_o.alu_op = ALU_LT;
    else if ((opc == OPC_GT) | bgt)     dec_o.alu_op = ALU_GT;
    else if (dec_o.mul)                 dec_o.alu_op = ALU_MUL;
    else                                dec_o.alu_op = ALU_ADD;
  end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage with a decode/execute pipeline register, valid/ready on both
// sides, load-use and MUL-latency interlocks, branch flush and imm widening.
`timescale 1ns/1ps
module decode_pipe
  import decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_opc,
  output logic [4:0]      out_ra,
  output logic [4:0]      out_rb,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic            out_we,
  output logic            out_ld,
  output logic            out_str,
  output logic            out_byt,
  output logic            out_brn,
  output logic            out_jmp,
  output logic            out_jlx,
  output logic            out_addi,
  output logic            out_mul,
  output logic            out_ill
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] MUL_RELOAD = CW'(MUL_LAT - 1);

  dec_t          in_dec;
  dec_t          out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] mul_cnt_q, mul_cnt_d;
  logic [4:0]    mul_rd_q, mul_rd_d;
  logic          lu_hazard, mul_hazard, hazard, load_en, in_fire;

  decode_comb u_decode_comb (
    .inst_i (in_inst),
    .dec_o  (in_dec)
  );

  always_comb begin
    lu_hazard  = in_valid & out_valid_q & out_q.ld &
                 ((out_q.rd == in_dec.ra) | (out_q.rd == in_dec.rb));
    mul_hazard = in_valid & (mul_cnt_q != '0) &
                 ((mul_rd_q == in_dec.ra) | (mul_rd_q == in_dec.rb));
    hazard     = lu_hazard | mul_hazard;
    load_en    = ~out_valid_q | out_ready;
    in_ready   = load_en & ~hazard & ~flush;
    in_fire    = in_valid & in_ready;
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    mul_rd_d    = mul_rd_q;
    mul_cnt_d   = (mul_cnt_q != '0) ? mul_cnt_q - CW'(1) : mul_cnt_q;

    if (flush) begin
      out_valid_d = 1'b0;
      mul_cnt_d   = '0;
    end else if (load_en) begin
      // A stalled input leaves a bubble behind when the register drains.
      out_valid_d = in_fire;
      if (in_fire) out_d = in_dec;
    end

    if (in_fire & in_dec.mul) begin
      mul_cnt_d = MUL_RELOAD;
      mul_rd_d  = in_dec.rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      mul_cnt_q   <= '0;
      mul_rd_q    <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      mul_cnt_q   <= mul_cnt_d;
      mul_rd_q    <= mul_rd_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_opc    = out_q.opc;
  assign out_ra     = out_q.ra;
  assign out_rb     = out_q.rb;
  assign out_rd     = out_q.rd;
  assign out_imm    = {{(XLEN-11){out_q.imm[10]}}, out_q.imm};
  assign out_alu_op = out_q.alu_op;
  assign out_we     = out_q.we;
  assign out_ld     = out_q.ld;
  assign out_str    = out_q.str;
  assign out_byt    = out_q.byt;
  assign out_brn    = out_q.brn;
  assign out_jmp    = out_q.jmp;
  assign out_jlx    = out_q.jlx;
  assign out_addi   = out_q.addi;
  assign out_mul    = out_q.mul;
  assign out_ill    = out_q.ill;

endmodule
